usb_tx_sched: RTL and testbench

//  Transmit scheduler in front of the USB bit-stream encoder. Arbitrates three requesters:

---
 rtl/usb_tx_sched_if.sv | 31 +++
 rtl/usb_tx_sched.sv | 143 ++++++++++++++
 tb/tb_usb_tx_sched.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_sched_if.sv
// rtl/usb_tx_sched_if.sv - requester, encoder and status signals of the USB transmit scheduler
interface usb_tx_sched_if;
    logic        hs_req;
    logic        hs_ack;
    logic        hs_done;
    logic        tok_req;
    logic        tok_in;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic        tok_done;
    logic        dat_req;
    logic [63:0] dat_payload;
    logic        dat_done;
    logic [98:0] pkt;
    logic        pkt_avail;
    logic        pkt_sent;
    logic        busy;
    logic        timeout_err;

    modport master (
        input  hs_req, hs_ack, tok_req, tok_in, tok_addr, tok_endp,
        input  dat_req, dat_payload, pkt_sent,
        output hs_done, tok_done, dat_done, pkt, pkt_avail, busy, timeout_err
    );

    modport slave (
        output hs_req, hs_ack, tok_req, tok_in, tok_addr, tok_endp,
        output dat_req, dat_payload, pkt_sent,
        input  hs_done, tok_done, dat_done, pkt, pkt_avail, busy, timeout_err
    );
endinterface

// File: rtl/usb_tx_sched.sv
// rtl/usb_tx_sched.sv - fixed-priority transmit scheduler feeding the USB bit-stream encoder
`ifndef ACKPID
`define ACKPID  8'hD2
`endif
`ifndef NAKPID
`define NAKPID  8'h5A
`endif
`ifndef INPID
`define INPID   8'h69
`endif
`ifndef OUTPID
`define OUTPID  8'hE1
`endif
`ifndef DATAPID
`define DATAPID 8'hC3
`endif

module usb_tx_sched #(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic           clk,
    input  logic           rst_b,
    usb_tx_sched_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
    typedef enum logic [1:0] {W_NONE, W_HS, W_TOK, W_DAT} who_t;

    localparam logic [7:0] SYNC     = 8'h01;
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      state, state_nxt;
    who_t        who, who_nxt;
    logic [7:0]  send_cnt, send_cnt_nxt;
    logic [3:0]  gap_cnt, gap_cnt_nxt;
    logic [98:0] pkt_q, pkt_nxt;
    logic        avail_q, avail_nxt;
    logic        busy_q, busy_nxt;
    logic        hs_done_q, hs_done_nxt;
    logic        tok_done_q, tok_done_nxt;
    logic        dat_done_q, dat_done_nxt;
    logic        terr_q, terr_nxt;
    logic        timed_out;

    assign timed_out = (send_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state      <= S_IDLE;
            who        <= W_NONE;
            send_cnt   <= '0;
            gap_cnt    <= '0;
            pkt_q      <= '0;
            avail_q    <= 1'b0;
            busy_q     <= 1'b0;
            hs_done_q  <= 1'b0;
            tok_done_q <= 1'b0;
            dat_done_q <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            who        <= who_nxt;
            send_cnt   <= send_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            pkt_q      <= pkt_nxt;
            avail_q    <= avail_nxt;
            busy_q     <= busy_nxt;
            hs_done_q  <= hs_done_nxt;
            tok_done_q <= tok_done_nxt;
            dat_done_q <= dat_done_nxt;
            terr_q     <= terr_nxt;
        end
    end

    // Arbitration happens only in IDLE, so a grant is never preempted.
    always_comb begin
        state_nxt = state;
        who_nxt   = who;
        unique case (state)
            S_IDLE: begin
                if (bus.hs_req) begin
                    who_nxt   = W_HS;
                    state_nxt = S_SEND;
                end else if (bus.tok_req) begin
                    who_nxt   = W_TOK;
                    state_nxt = S_SEND;
                end else if (bus.dat_req) begin
                    who_nxt   = W_DAT;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: if (bus.pkt_sent || timed_out) state_nxt = S_GAP;
            S_GAP:  if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pkt_nxt      = pkt_q;
        send_cnt_nxt = '0;
        gap_cnt_nxt  = '0;
        hs_done_nxt  = 1'b0;
        tok_done_nxt = 1'b0;
        dat_done_nxt = 1'b0;
        terr_nxt     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (state_nxt == S_SEND) begin
                    unique case (who_nxt)
                        W_HS:    pkt_nxt = {SYNC, (bus.hs_ack ? `ACKPID : `NAKPID), 83'd0};
                        W_TOK:   pkt_nxt = {SYNC, (bus.tok_in ? `INPID : `OUTPID),
                                            bus.tok_addr, bus.tok_endp, 72'd0};
                        W_DAT:   pkt_nxt = {SYNC, `DATAPID, bus.dat_payload, 19'd0};
                        default: pkt_nxt = pkt_q;
                    endcase
                end
            end
            S_SEND: begin
                send_cnt_nxt = send_cnt + 8'd1;
                if (state_nxt == S_GAP) begin
                    hs_done_nxt  = (who == W_HS);
                    tok_done_nxt = (who == W_TOK);
                    dat_done_nxt = (who == W_DAT);
                    // A completion arriving on the timeout cycle still counts as success.
                    terr_nxt     = !bus.pkt_sent;
                end
            end
            S_GAP: gap_cnt_nxt = gap_cnt + 4'd1;
            default: ;
        endcase
        avail_nxt = (state_nxt == S_SEND);
        busy_nxt  = (state_nxt != S_IDLE);
    end

    assign bus.pkt         = pkt_q;
    assign bus.pkt_avail   = avail_q;
    assign bus.busy        = busy_q;
    assign bus.hs_done     = hs_done_q;
    assign bus.tok_done    = tok_done_q;
    assign bus.dat_done    = dat_done_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_usb_tx_sched.sv
// tb/tb_usb_tx_sched.sv - scoreboard bench for usb_tx_sched
module tb_usb_tx_sched;
    localparam int GAP = 2;
    localparam int TMO = 255;
    localparam logic [7:0] P_ACK = 8'hD2, P_NAK = 8'h5A, P_IN = 8'h69, P_OUT = 8'hE1, P_DAT = 8'hC3;

    typedef struct {
        logic [98:0] pkt;
        logic [2:0]  who;
        logic        to;
        int          len;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    usb_tx_sched_if bus_if();
    usb_tx_sched #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (.clk(clk), .rst_b(rst_b), .bus(bus_if));

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   sent_delay = 5;
    bit   mon_first = 1'b1;
    int   acnt = 0;
    int   avail_len = 0;
    int   idle_len = 0;
    logic prev_avail = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [98:0] p, input logic [2:0] w);
        exp_t e;
        e.pkt = p;
        e.who = w;
        e.to  = (sent_delay == 0);
        e.len = (sent_delay == 0) ? TMO : sent_delay;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int lim);
        int n = 0;
        while (!(bus_if.hs_done || bus_if.tok_done || bus_if.dat_done) && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) chk({tag, "_done_wait"}, 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus_if.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_wait", 0, 1);
    endtask

    // Encoder model: strobes pkt_sent on the sent_delay-th pkt_avail cycle (0 = never).
    initial begin
        bus_if.pkt_sent = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.pkt_avail) begin
                acnt++;
                bus_if.pkt_sent = (sent_delay != 0 && acnt == sent_delay);
            end else begin
                acnt = 0;
                bus_if.pkt_sent = 1'b0;
            end
        end
    end

    // Requesters hold req until their done pulse.
    initial forever begin
        @(negedge clk);
        if (bus_if.hs_done)  bus_if.hs_req  = 1'b0;
        if (bus_if.tok_done) bus_if.tok_req = 1'b0;
        if (bus_if.dat_done) bus_if.dat_req = 1'b0;
    end

    initial forever begin
        logic [2:0] dn;
        exp_t e;
        @(negedge clk);
        if (!rst_b) begin
            dn = {bus_if.hs_done, bus_if.tok_done, bus_if.dat_done};
            if (bus_if.pkt_avail) begin
                if (!prev_avail) begin
                    if (!mon_first) chk("gap_len", idle_len >= GAP + 1, 1);
                    mon_first = 1'b0;
                    avail_len = 0;
                    if (exp_q.size() != 0) chk("pkt", bus_if.pkt, exp_q[0].pkt);
                    else chk("pkt_unexpected", 1, 0);
                end
                avail_len++;
            end else begin
                if (prev_avail) idle_len = 0;
                idle_len++;
            end
            if (dn != 3'b000) begin
                if (exp_q.size() == 0) chk("done_unexpected", dn, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("done_who", dn, e.who);
                    chk("timeout_err", bus_if.timeout_err, e.to);
                    chk("send_len", avail_len, e.len);
                    chk("pkt_hold", bus_if.pkt, e.pkt);
                end
            end else if (bus_if.timeout_err) chk("terr_alone", 1, 0);
        end
        prev_avail = bus_if.pkt_avail;
    end

    initial begin
        logic [63:0] pl;
        logic [6:0]  ad;
        logic [3:0]  ep;
        logic        b;
        rst_b = 1'b1;
        bus_if.hs_req = 0; bus_if.hs_ack = 0; bus_if.tok_req = 0; bus_if.tok_in = 0;
        bus_if.tok_addr = 0; bus_if.tok_endp = 0; bus_if.dat_req = 0; bus_if.dat_payload = 0;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        chk("rst_avail", bus_if.pkt_avail, 0);
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_pkt", bus_if.pkt, 0);
        chk("rst_done", {bus_if.hs_done, bus_if.tok_done, bus_if.dat_done, bus_if.timeout_err}, 0);

        // Handshake ACK, completion after 11 cycles
        sent_delay = 11;
        bus_if.hs_ack = 1; bus_if.hs_req = 1;
        push({8'h01, P_ACK, 83'd0}, 3'b100);
        @(negedge clk);
        chk("t1_avail", bus_if.pkt_avail, 1);
        chk("t1_pid", bus_if.pkt[90:83], P_ACK);
        chk("t1_low", bus_if.pkt[82:0], 0);
        wait_done("t1", 50);
        chk("t1_avail_off", bus_if.pkt_avail, 0);
        chk("t1_busy_g1", bus_if.busy, 1);
        @(negedge clk);
        chk("t1_pulse", bus_if.hs_done, 0);
        chk("t1_busy_g2", bus_if.busy, 1);
        @(negedge clk);
        chk("t1_busy_end", bus_if.busy, 0);

        // OUT token
        sent_delay = 3;
        bus_if.tok_in = 0; bus_if.tok_addr = 7'h5A; bus_if.tok_endp = 4'h3; bus_if.tok_req = 1;
        push({8'h01, P_OUT, 7'h5A, 4'h3, 72'd0}, 3'b010);
        @(negedge clk);
        chk("t2_sync", bus_if.pkt[98:91], 8'h01);
        chk("t2_addr", bus_if.pkt[82:76], 7'h5A);
        chk("t2_endp", bus_if.pkt[75:72], 4'h3);
        wait_done("t2", 50);
        wait_idle();

        // All three requests in the same cycle
        sent_delay = 4;
        pl = {$urandom, $urandom};
        ad = 7'($urandom); ep = 4'($urandom);
        bus_if.hs_ack = 0; bus_if.tok_in = 1; bus_if.tok_addr = ad; bus_if.tok_endp = ep;
        bus_if.dat_payload = pl;
        bus_if.hs_req = 1; bus_if.tok_req = 1; bus_if.dat_req = 1;
        push({8'h01, P_NAK, 83'd0}, 3'b100);
        push({8'h01, P_IN, ad, ep, 72'd0}, 3'b010);
        push({8'h01, P_DAT, pl, 19'd0}, 3'b001);
        for (int i = 0; i < 3; i++) begin
            wait_done("t3", 50);
            @(negedge clk);
        end
        wait_idle();

        // Data packet with a stalled encoder
        sent_delay = 0;
        bus_if.dat_payload = 64'hDEAD_BEEF_0123_4567; bus_if.dat_req = 1;
        push({8'h01, P_DAT, 64'hDEAD_BEEF_0123_4567, 19'd0}, 3'b001);
        @(negedge clk);
        wait_done("t4", 400);
        chk("t4_terr", bus_if.timeout_err, 1);
        chk("t4_avail", bus_if.pkt_avail, 0);
        wait_idle();

        // Completion on the same cycle as the timeout
        sent_delay = TMO;
        bus_if.hs_ack = 1; bus_if.hs_req = 1;
        push({8'h01, P_ACK, 83'd0}, 3'b100);
        @(negedge clk);
        wait_done("t4b", 400);
        chk("t4b_terr", bus_if.timeout_err, 0);
        wait_idle();

        // Reset in the middle of a data SEND
        sent_delay = 0;
        bus_if.dat_payload = {$urandom, $urandom}; bus_if.dat_req = 1;
        push({8'h01, P_DAT, bus_if.dat_payload, 19'd0}, 3'b001);
        repeat (6) @(negedge clk);
        rst_b = 1'b1; bus_if.dat_req = 0;
        @(negedge clk);
        chk("t5_avail", bus_if.pkt_avail, 0);
        chk("t5_busy", bus_if.busy, 0);
        chk("t5_nodone", {bus_if.hs_done, bus_if.tok_done, bus_if.dat_done, bus_if.timeout_err}, 0);
        rst_b = 1'b0;
        exp_q.delete();
        mon_first = 1'b1;
        @(negedge clk);
        chk("t5_nodone2", {bus_if.hs_done, bus_if.tok_done, bus_if.dat_done, bus_if.timeout_err}, 0);
        sent_delay = 7;
        bus_if.dat_payload = 64'h0123_4567_89AB_CDEF; bus_if.dat_req = 1;
        push({8'h01, P_DAT, 64'h0123_4567_89AB_CDEF, 19'd0}, 3'b001);
        @(negedge clk);
        wait_done("t5", 50);
        wait_idle();

        // Token dropped and fields changed mid-SEND
        sent_delay = 10;
        bus_if.tok_in = 1; bus_if.tok_addr = 7'h11; bus_if.tok_endp = 4'h9; bus_if.tok_req = 1;
        push({8'h01, P_IN, 7'h11, 4'h9, 72'd0}, 3'b010);
        repeat (3) @(negedge clk);
        bus_if.tok_req = 0; bus_if.tok_addr = 7'h7F; bus_if.tok_endp = 4'hF; bus_if.tok_in = 0;
        @(negedge clk);
        chk("t6_frozen", bus_if.pkt, {8'h01, P_IN, 7'h11, 4'h9, 72'd0});
        wait_done("t6", 50);
        wait_idle();

        // Random single requests
        for (int i = 0; i < 8; i++) begin
            int k;
            k = $urandom_range(0, 2);
            sent_delay = $urandom_range(1, 30);
            if (k == 0) begin
                b = 1'($urandom);
                bus_if.hs_ack = b; bus_if.hs_req = 1;
                push({8'h01, (b ? P_ACK : P_NAK), 83'd0}, 3'b100);
            end else if (k == 1) begin
                b = 1'($urandom); ad = 7'($urandom); ep = 4'($urandom);
                bus_if.tok_in = b; bus_if.tok_addr = ad; bus_if.tok_endp = ep; bus_if.tok_req = 1;
                push({8'h01, (b ? P_IN : P_OUT), ad, ep, 72'd0}, 3'b010);
            end else begin
                pl = {$urandom, $urandom};
                bus_if.dat_payload = pl; bus_if.dat_req = 1;
                push({8'h01, P_DAT, pl, 19'd0}, 3'b001);
            end
            @(negedge clk);
            wait_done("rnd", 80);
            wait_idle();
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
